csr_reg: RTL and testbench
==========================

Name: csr_reg

Overview:
- Machine-mode CSR register file.
- Responder end of the CSR write/read interface driven by the interrupt controller (clint) and by the execute stage.
- Holds mstatus, mie, mtvec, mscratch, mepc, mcause and a free-running 64-bit cycle counter.
- Supplies the trap vector, return address, status word and global interrupt enable back to clint, and CSR read data to ex.

Parameters:
- CYCLE_W, 64, width of cycle counter (low half at mcycle, high half at mcycleh).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- we_i  in  1  ex CSR write enable
- raddr_i  in  32  ex CSR read address (bits [11:0] decoded)
- waddr_i  in  32  ex CSR write address (bits [11:0] decoded)
- data_i  in  32  ex CSR write data
- data_o  out  32  ex CSR read data (combinational)
- clint_we_i  in  1  clint CSR write enable
- clint_raddr_i  in  32  clint CSR read address
- clint_waddr_i  in  32  clint CSR write address
- clint_data_i  in  32  clint CSR write data
- clint_data_o  out  32  clint CSR read data (combinational)
- clint_csr_mtvec  out  32  current mtvec register
- clint_csr_mepc  out  32  current mepc register
- clint_csr_mstatus  out  32  current mstatus register
- global_int_en_o  out  1  mstatus[3] (MIE)

Behaviour:
- Address map (bits [11:0]):
  - Read/write: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80.
  - Read-only aliases: cycle 0xC00, cycleh 0xC80.
  - Bits [31:12] of every address are ignored.
- Reset (rst=1, async): every register and the counter go to 0 immediately. Hence data_o=0, clint_data_o=0, clint_csr_* = 0, global_int_en_o=0. Reset asserted mid-write discards the write.
- Writes take effect on the rising clk edge.
  - All 32 bits are writable in every RW register; no WARL masking.
  - Writes to read-only or unmapped addresses are ignored.
- Write arbitration:
  - we_i=1 → the ex write is performed; a simultaneous clint write is dropped, even to a different address.
  - we_i=0 and clint_we_i=1 → the clint write is performed.
  - At most one CSR is written per cycle.
- Cycle counter:
  - Increments by 1 every cycle when out of reset; wraps from 2^64-1 to 0.
  - A write to mcycle replaces bits [31:0] of the incremented value; a write to mcycleh replaces bits [63:32] of the incremented value. The unwritten half takes the incremented result, including carry.
- Read ports are combinational decodes of current register state.
  - Unmapped addresses read 0.
  - cycle/mcycle return bits [31:0]; cycleh/mcycleh return bits [63:32] of the pre-increment value.
- Bypass on the ex port:
  - If we_i=1 and waddr_i[11:0]==raddr_i[11:0] at a writable address, data_o = data_i.
  - Otherwise data_o is the decoded register.
- Bypass on the clint port:
  - If clint_we_i=1 and clint_waddr_i[11:0]==clint_raddr_i[11:0] at a writable address, clint_data_o = clint_data_i.
  - Otherwise clint_data_o is the decoded register.
- clint_csr_mtvec, clint_csr_mepc, clint_csr_mstatus and global_int_en_o are direct register values with no bypass. A write becomes visible one cycle after its edge-sampling cycle. clint relies on this ordering: it writes mepc → mstatus → mcause, then reads mtvec.
- Latency: write-to-register 1 edge; read 0 cycles.

Test Plan:
- Reset release, no writes → data_o=0 for mstatus, and mcycle reads 0,1,2… in consecutive cycles. Assert rst mid-run → all outputs 0 asynchronously, before the next edge.
- Ex write mtvec=0x0000_0100 → clint_csr_mtvec=0x100 the following cycle. Same-cycle read raddr_i=0x305 returns 0x100 via bypass.
- clint sequence: mepc=0x0000_0040, mstatus=0x0000_0000 (from 0x8), mcause=0x8000_0004 → global_int_en_o falls 1→0 after the mstatus edge. clint_csr_mepc=0x40; reading 0x342 gives 0x8000_0004.
- Simultaneous we_i (mscratch=0xAAAA_5555) and clint_we_i (mepc=0x1234) → mscratch updated; mepc unchanged.
- Counter at 0x0000_0000_FFFF_FFFF → next cycle reads mcycle=0, mcycleh=1. Writing mcycleh=0x7 at that edge → {0x7, 0x0000_0000}.
- Writes to 0xC00 and to 0x7C0 → no state change; reads of 0x7C0 return 0. Address 0xFFFF_F300 aliases mstatus.

Source files
------------

// File: rtl/csr_reg.sv
// Machine-mode CSR register file. Owns mstatus, mie, mtvec, mscratch, mepc,
// mcause and the free-running cycle counter. It serves two read/write ports:
// one for the execute stage and one for the interrupt controller (clint).
module csr_reg #(
  parameter int unsigned CYCLE_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] raddr_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        clint_we_i,
  input  logic [31:0] clint_raddr_i,
  input  logic [31:0] clint_waddr_i,
  input  logic [31:0] clint_data_i,
  output logic [31:0] clint_data_o,
  output logic [31:0] clint_csr_mtvec,
  output logic [31:0] clint_csr_mepc,
  output logic [31:0] clint_csr_mstatus,
  output logic        global_int_en_o
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned MIE_BIT = 3;

  localparam logic [ADDR_W-1:0] A_MSTATUS  = 12'h300;
  localparam logic [ADDR_W-1:0] A_MIE      = 12'h304;
  localparam logic [ADDR_W-1:0] A_MTVEC    = 12'h305;
  localparam logic [ADDR_W-1:0] A_MSCRATCH = 12'h340;
  localparam logic [ADDR_W-1:0] A_MEPC     = 12'h341;
  localparam logic [ADDR_W-1:0] A_MCAUSE   = 12'h342;
  localparam logic [ADDR_W-1:0] A_MCYCLE   = 12'hB00;
  localparam logic [ADDR_W-1:0] A_MCYCLEH  = 12'hB80;
  localparam logic [ADDR_W-1:0] A_CYCLE    = 12'hC00;
  localparam logic [ADDR_W-1:0] A_CYCLEH   = 12'hC80;

  logic [XLEN-1:0]    mstatus_q;
  logic [XLEN-1:0]    mie_q;
  logic [XLEN-1:0]    mtvec_q;
  logic [XLEN-1:0]    mscratch_q;
  logic [XLEN-1:0]    mepc_q;
  logic [XLEN-1:0]    mcause_q;
  logic [CYCLE_W-1:0] cycle_q;
  logic [CYCLE_W-1:0] cycle_inc;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [XLEN-1:0]    wr_data;

  logic [ADDR_W-1:0]  ex_raddr;
  logic [ADDR_W-1:0]  ex_waddr;
  logic [ADDR_W-1:0]  cl_raddr;
  logic [ADDR_W-1:0]  cl_waddr;

  // Only the low 12 address bits select a CSR; the rest are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr_i[31:ADDR_W], waddr_i[31:ADDR_W],
                              clint_raddr_i[31:ADDR_W], clint_waddr_i[31:ADDR_W]};

  assign ex_raddr = raddr_i[ADDR_W-1:0];
  assign ex_waddr = waddr_i[ADDR_W-1:0];
  assign cl_raddr = clint_raddr_i[ADDR_W-1:0];
  assign cl_waddr = clint_waddr_i[ADDR_W-1:0];

  // True for addresses that accept writes (read-only aliases excluded).
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    logic ok;
    ok = 1'b0;
    case (a)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
      A_MEPC, A_MCAUSE, A_MCYCLE, A_MCYCLEH: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Register read decode; unmapped addresses read as zero.
  function automatic logic [XLEN-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [XLEN-1:0] r;
    r = '0;
    case (a)
      A_MSTATUS:          r = mstatus_q;
      A_MIE:              r = mie_q;
      A_MTVEC:            r = mtvec_q;
      A_MSCRATCH:         r = mscratch_q;
      A_MEPC:             r = mepc_q;
      A_MCAUSE:           r = mcause_q;
      A_MCYCLE, A_CYCLE:  r = cycle_q[XLEN-1:0];
      A_MCYCLEH, A_CYCLEH: r = XLEN'(cycle_q[CYCLE_W-1:XLEN]);
      default:            r = '0;
    endcase
    return r;
  endfunction

  // Write arbitration: the execute stage always wins over clint.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (we_i) begin
      wr_en   = 1'b1;
      wr_addr = ex_waddr;
      wr_data = data_i;
    end else if (clint_we_i) begin
      wr_en   = 1'b1;
      wr_addr = cl_waddr;
      wr_data = clint_data_i;
    end
  end

  assign cycle_inc = cycle_q + CYCLE_W'(1);

  // CSR state update; a counter-half write overrides that half of the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      cycle_q    <= '0;
    end else begin
      cycle_q <= cycle_inc;
      if (wr_en) begin
        case (wr_addr)
          A_MSTATUS:  mstatus_q  <= wr_data;
          A_MIE:      mie_q      <= wr_data;
          A_MTVEC:    mtvec_q    <= wr_data;
          A_MSCRATCH: mscratch_q <= wr_data;
          A_MEPC:     mepc_q     <= wr_data;
          A_MCAUSE:   mcause_q   <= wr_data;
          A_MCYCLE:   cycle_q    <= {cycle_inc[CYCLE_W-1:XLEN], wr_data};
          A_MCYCLEH:  cycle_q    <= {wr_data, cycle_inc[XLEN-1:0]};
          default: ;
        endcase
      end
    end
  end

  // Execute-port read with same-cycle write bypass.
  always_comb begin
    data_o = decode(ex_raddr);
    if (we_i && (ex_waddr == ex_raddr) && writable(ex_waddr)) begin
      data_o = data_i;
    end
  end

  // Clint-port read with same-cycle write bypass.
  always_comb begin
    clint_data_o = decode(cl_raddr);
    if (clint_we_i && (cl_waddr == cl_raddr) && writable(cl_waddr)) begin
      clint_data_o = clint_data_i;
    end
  end

  assign clint_csr_mtvec   = mtvec_q;
  assign clint_csr_mepc    = mepc_q;
  assign clint_csr_mstatus = mstatus_q;
  assign global_int_en_o   = mstatus_q[MIE_BIT];

endmodule

// File: tb/tb_csr_reg.sv
// Self-checking bench for csr_reg: hand vectors, counter/reset sequences and
// randomized traffic compared against a behavioural CSR model.
module tb_csr_reg;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [31:0] raddr_i, waddr_i, data_i, data_o;
  logic        clint_we_i;
  logic [31:0] clint_raddr_i, clint_waddr_i, clint_data_i, clint_data_o;
  logic [31:0] clint_csr_mtvec, clint_csr_mepc, clint_csr_mstatus;
  logic        global_int_en_o;

  int n_chk;
  int n_fail;

  csr_reg #(.CYCLE_W(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .we_i              (we_i),
    .raddr_i           (raddr_i),
    .waddr_i           (waddr_i),
    .data_i            (data_i),
    .data_o            (data_o),
    .clint_we_i        (clint_we_i),
    .clint_raddr_i     (clint_raddr_i),
    .clint_waddr_i     (clint_waddr_i),
    .clint_data_i      (clint_data_i),
    .clint_data_o      (clint_data_o),
    .clint_csr_mtvec   (clint_csr_mtvec),
    .clint_csr_mepc    (clint_csr_mepc),
    .clint_csr_mstatus (clint_csr_mstatus),
    .global_int_en_o   (global_int_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0]     m_csr [int];
  longint unsigned m_cyc;

  function automatic void m_reset();
    int keys [6] = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342};
    m_csr.delete();
    foreach (keys[i]) m_csr[keys[i]] = 32'h0;
    m_cyc = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int k;
    k = int'(a[11:0]);
    if (k == 'hB00 || k == 'hC00) return m_cyc[31:0];
    if (k == 'hB80 || k == 'hC80) return m_cyc[63:32];
    if (m_csr.exists(k)) return m_csr[k];
    return 32'h0;
  endfunction

  function automatic bit m_writable(input logic [31:0] a);
    int k;
    k = int'(a[11:0]);
    return m_csr.exists(k) || k == 'hB00 || k == 'hB80;
  endfunction

  function automatic logic [31:0] m_port(input logic we, input logic [31:0] ra,
                                         input logic [31:0] wa, input logic [31:0] d);
    if (we && ra[11:0] == wa[11:0] && m_writable(wa)) return d;
    return m_read(ra);
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d);
    int k;
    k = int'(a[11:0]);
    if (k == 'hB00)          m_cyc[31:0]  = d;
    else if (k == 'hB80)     m_cyc[63:32] = d;
    else if (m_csr.exists(k)) m_csr[k]    = d;
  endfunction

  function automatic void m_step();
    m_cyc = m_cyc + 1;
    if (we_i)            m_write(waddr_i, data_i);
    else if (clint_we_i) m_write(clint_waddr_i, clint_data_i);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) m_step();
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] ra, input logic [31:0] wa,
                       input logic [31:0] d, input logic cwe, input logic [31:0] cra,
                       input logic [31:0] cwa, input logic [31:0] cd);
    we_i = we; raddr_i = ra; waddr_i = wa; data_i = d;
    clint_we_i = cwe; clint_raddr_i = cra; clint_waddr_i = cwa; clint_data_i = cd;
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data_o"}, data_o, m_port(we_i, raddr_i, waddr_i, data_i));
    chk({tag, ".clint_data_o"}, clint_data_o,
        m_port(clint_we_i, clint_raddr_i, clint_waddr_i, clint_data_i));
    chk({tag, ".mtvec"}, clint_csr_mtvec, m_read(32'h305));
    chk({tag, ".mepc"}, clint_csr_mepc, m_read(32'h341));
    chk({tag, ".mstatus"}, clint_csr_mstatus, m_read(32'h300));
    chk({tag, ".gie"}, 32'(global_int_en_o), 32'(m_read(32'h300) >> 3) & 32'h1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] raddr, waddr, data;
    logic        cwe;
    logic [31:0] craddr, cwaddr, cdata;
    logic [31:0] e_data, e_cdata, e_mtvec, e_mepc, e_mstatus;
    logic        e_gie;
  } vec_t;

  vec_t tv [13];

  logic [31:0] addr_pool [12];

  initial begin
    // we raddr waddr data | cwe craddr cwaddr cdata | data_o clint_data_o | mtvec mepc mstatus gie
    tv[0]  = '{1, 'h305, 'h305, 'h100, 0, 'h305, 'h0, 'h0, 'h100, 'h0, 'h100, 'h0, 'h0, 0};
    tv[1]  = '{1, 'h305, 'h300, 'h8, 0, 'h300, 'h0, 'h0, 'h100, 'h0, 'h100, 'h0, 'h8, 1};
    tv[2]  = '{0, 'h300, 'h0, 'h0, 1, 'h341, 'h341, 'h40, 'h8, 'h40, 'h100, 'h40, 'h8, 1};
    tv[3]  = '{0, 'h341, 'h0, 'h0, 1, 'h305, 'h300, 'h0, 'h40, 'h100, 'h100, 'h40, 'h0, 0};
    tv[4]  = '{0, 'h342, 'h0, 'h0, 1, 'h342, 'h342, 'h80000004, 'h0, 'h80000004, 'h100, 'h40, 'h0, 0};
    tv[5]  = '{0, 'h342, 'h0, 'h0, 0, 'h300, 'h0, 'h0, 'h80000004, 'h0, 'h100, 'h40, 'h0, 0};
    tv[6]  = '{1, 'h340, 'h340, 'hAAAA5555, 1, 'h300, 'h341, 'h1234, 'hAAAA5555, 'h0, 'h100, 'h40, 'h0, 0};
    tv[7]  = '{0, 'h340, 'h0, 'h0, 0, 'h341, 'h0, 'h0, 'hAAAA5555, 'h40, 'h100, 'h40, 'h0, 0};
    tv[8]  = '{1, 'h7C0, 'hC00, 'hDEAD, 1, 'h7C0, 'h7C0, 'hBEEF, 'h0, 'h0, 'h100, 'h40, 'h0, 0};
    tv[9]  = '{1, 'hFFFFF300, 'hFFFFF300, 'h8, 0, 'hABCD0300, 'h0, 'h0, 'h8, 'h0, 'h100, 'h40, 'h8, 1};
    tv[10] = '{0, 'h12345300, 'h0, 'h0, 1, 'h7C0, 'h7C0, 'h5, 'h8, 'h0, 'h100, 'h40, 'h8, 1};
    tv[11] = '{1, 'h304, 'h304, 'hFFFFFFFF, 0, 'h304, 'h0, 'h0, 'hFFFFFFFF, 'h0, 'h100, 'h40, 'h8, 1};
    tv[12] = '{0, 'h304, 'h0, 'h0, 0, 'h7C0, 'h0, 'h0, 'hFFFFFFFF, 'h0, 'h100, 'h40, 'h8, 1};

    addr_pool = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342,
                  'hB00, 'hB80, 'hC00, 'hC80, 'h7C0, 'h000};

    n_chk = 0;
    n_fail = 0;
    m_reset();
    rst = 1'b1;
    drive(0, 'h300, 0, 0, 0, 'h300, 0, 0);

    // Reset release: registers zero, counter counts 0,1,2,3.
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 'h300, 0, 0, 0, 'hB00, 0, 0);
    chk("rst.data_o", data_o, 32'h0);
    chk("rst.mstatus", clint_csr_mstatus, 32'h0);
    chk("rst.gie", 32'(global_int_en_o), 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("count%0d", k), clint_data_o, 32'(k));
      tick();
    end

    // Vector table.
    foreach (tv[i]) begin
      drive(tv[i].we, tv[i].raddr, tv[i].waddr, tv[i].data,
            tv[i].cwe, tv[i].craddr, tv[i].cwaddr, tv[i].cdata);
      chk($sformatf("tv%0d.data_o", i), data_o, tv[i].e_data);
      chk($sformatf("tv%0d.clint_data_o", i), clint_data_o, tv[i].e_cdata);
      tick();
      chk($sformatf("tv%0d.mtvec", i), clint_csr_mtvec, tv[i].e_mtvec);
      chk($sformatf("tv%0d.mepc", i), clint_csr_mepc, tv[i].e_mepc);
      chk($sformatf("tv%0d.mstatus", i), clint_csr_mstatus, tv[i].e_mstatus);
      chk($sformatf("tv%0d.gie", i), 32'(global_int_en_o), 32'(tv[i].e_gie));
    end

    // Counter carry from low half into high half.
    drive(1, 'h0, 'hB80, 'h0, 0, 'h0, 0, 0); tick();
    drive(1, 'hB00, 'hB00, 'hFFFFFFFF, 0, 'h0, 0, 0);
    chk("cyc.bypass", data_o, 32'hFFFFFFFF);
    tick();
    drive(0, 'hB00, 0, 0, 0, 'hB80, 0, 0);
    chk("cyc.lo_pre", data_o, 32'hFFFFFFFF);
    chk("cyc.hi_pre", clint_data_o, 32'h0);
    tick();
    drive(0, 'hC00, 0, 0, 0, 'hC80, 0, 0);
    chk("cyc.lo_wrap", data_o, 32'h0);
    chk("cyc.hi_wrap", clint_data_o, 32'h1);

    // mcycleh write at the carry edge keeps the incremented low half.
    drive(1, 'h0, 'hB80, 'h0, 0, 'h0, 0, 0); tick();
    drive(1, 'h0, 'hB00, 'hFFFFFFFF, 0, 'h0, 0, 0); tick();
    drive(1, 'hB00, 'hB80, 'h7, 0, 'hC80, 0, 0);
    chk("cych.lo_pre", data_o, 32'hFFFFFFFF);
    chk("cych.hi_pre", clint_data_o, 32'h0);
    tick();
    drive(0, 'hB00, 0, 0, 0, 'hB80, 0, 0);
    chk("cych.lo", data_o, 32'h0);
    chk("cych.hi", clint_data_o, 32'h7);
    chk("cych.model_lo", data_o, m_read(32'hB00));
    chk("cych.model_hi", clint_data_o, m_read(32'hB80));

    // Asynchronous reset mid-run, then a write held across an edge in reset.
    drive(0, 'h300, 0, 0, 0, 'h305, 0, 0);
    chk("pre_rst.mstatus", data_o, 32'h8);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk("arst.data_o", data_o, 32'h0);
    chk("arst.clint_data_o", clint_data_o, 32'h0);
    chk("arst.mtvec", clint_csr_mtvec, 32'h0);
    chk("arst.mepc", clint_csr_mepc, 32'h0);
    chk("arst.mstatus", clint_csr_mstatus, 32'h0);
    chk("arst.gie", 32'(global_int_en_o), 32'h0);
    drive(1, 'h0, 'h305, 'h55, 0, 'hB00, 0, 0);
    tick();
    chk("rstwr.mtvec", clint_csr_mtvec, 32'h0);
    chk("rstwr.cycle", clint_data_o, 32'h0);
    drive(0, 'h305, 0, 0, 0, 'hB00, 0, 0);
    rst = 1'b0;
    tick();
    chk("post_rst.mtvec", data_o, 32'h0);
    chk("post_rst.cycle", clint_data_o, 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        r_we, r_cwe;
      logic [31:0] r_ra, r_wa, r_cra, r_cwa;
      r_we  = ($urandom_range(0, 2) == 0);
      r_cwe = ($urandom_range(0, 2) == 0);
      r_wa  = {$urandom_range(0, 'hFFFFF), 12'h0} | addr_pool[$urandom_range(0, 11)];
      r_cwa = {$urandom_range(0, 'hFFFFF), 12'h0} | addr_pool[$urandom_range(0, 11)];
      r_ra  = ($urandom_range(0, 3) == 0) ? r_wa : addr_pool[$urandom_range(0, 11)];
      r_cra = ($urandom_range(0, 3) == 0) ? r_cwa : addr_pool[$urandom_range(0, 11)];
      drive(r_we, r_ra, r_wa, $urandom, r_cwe, r_cra, r_cwa, $urandom);
      chk_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
